// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master front end between NREQ requesters.
// One transfer in flight; per-transfer watchdog aborts accesses that never complete.
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 9,
  parameter int DW      = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_wr,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 err,
  output logic                 m_transfer,
  output logic                 m_wr_rd,
  output logic [AW-1:0]        m_wr_addr,
  output logic [AW-1:0]        m_rd_addr,
  output logic [DW-1:0]        m_wr_data,
  input  logic                 m_done,
  input  logic [DW-1:0]        m_rdata,
  input  logic                 m_slverr
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              m_transfer_q, m_transfer_d;
  logic              m_wr_rd_q, m_wr_rd_d;
  logic [AW-1:0]     m_wr_addr_q, m_wr_addr_d;
  logic [AW-1:0]     m_rd_addr_q, m_rd_addr_d;
  logic [DW-1:0]     m_wr_data_q, m_wr_data_d;

  logic [2*NREQ-1:0] dbl_s;
  logic [NREQ-1:0]   rot_s;
  logic [PW-1:0]     off_s;
  logic [PW-1:0]     pick_s;
  logic              found_s;
  logic              pick_wr_s;
  logic [AW-1:0]     pick_addr_s;
  logic [DW-1:0]     pick_wdata_s;

  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = (s >= (PW+1)'(NREQ)) ? (s - (PW+1)'(NREQ)) : s;
    return s[PW-1:0];
  endfunction

  // Rotate requests so bit 0 is the pointer position; lowest set bit is the winner.
  always_comb begin
    dbl_s   = {req, req} >> ptr_q;
    rot_s   = dbl_s[NREQ-1:0];
    found_s = |req;
    off_s   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? PW'(i) : off_s;
    end
    pick_s       = wrap_add(ptr_q, off_s);
    pick_wr_s    = req_wr[pick_s];
    pick_addr_s  = AW'(req_addr >> (pick_s * AW));
    pick_wdata_s = DW'(req_wdata >> (pick_s * DW));
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    wd_d         = wd_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    m_transfer_d = m_transfer_q;
    m_wr_rd_d    = m_wr_rd_q;
    m_wr_addr_d  = m_wr_addr_q;
    m_rd_addr_d  = m_rd_addr_q;
    m_wr_data_d  = m_wr_data_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          grant_d      = pick_s;
          m_transfer_d = 1'b1;
          m_wr_rd_d    = pick_wr_s;
          m_wr_addr_d  = pick_wr_s ? pick_addr_s : '0;
          m_rd_addr_d  = pick_wr_s ? '0 : pick_addr_s;
          m_wr_data_d  = pick_wr_s ? pick_wdata_s : '0;
          wd_d         = '0;
          state_d      = S_BUSY;
        end else begin
          m_transfer_d = 1'b0;
        end
      end
      // A completion on the final watchdog cycle still counts as a normal finish.
      S_BUSY: begin
        if (m_done) begin
          rdata_d      = m_wr_rd_q ? '0 : m_rdata;
          err_d        = m_slverr;
          m_transfer_d = 1'b0;
          ack_d        = NREQ'(1) << grant_q;
          state_d      = S_RESP;
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          rdata_d      = '0;
          err_d        = 1'b1;
          m_transfer_d = 1'b0;
          ack_d        = NREQ'(1) << grant_q;
          state_d      = S_RESP;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_RESP: begin
        ptr_d   = wrap_add(grant_q, PW'(1));
        wd_d    = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_q      <= '0;
      wd_q         <= '0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      m_transfer_q <= 1'b0;
      m_wr_rd_q    <= 1'b0;
      m_wr_addr_q  <= '0;
      m_rd_addr_q  <= '0;
      m_wr_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      wd_q         <= wd_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      m_transfer_q <= m_transfer_d;
      m_wr_rd_q    <= m_wr_rd_d;
      m_wr_addr_q  <= m_wr_addr_d;
      m_rd_addr_q  <= m_rd_addr_d;
      m_wr_data_q  <= m_wr_data_d;
    end
  end

  assign ack        = ack_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign m_transfer = m_transfer_q;
  assign m_wr_rd    = m_wr_rd_q;
  assign m_wr_addr  = m_wr_addr_q;
  assign m_rd_addr  = m_rd_addr_q;
  assign m_wr_data  = m_wr_data_q;

endmodule
